mmio_write_unit: RTL and testbench
==================================

Name: mmio_write_unit

Overview:
- Store-side and bookkeeping half of the memory-mapped IO region (addr[31:30] = 2'b10).
- Sits in stage 3 next to the IO read mux and owns everything that stores or retirements mutate:
  - UART transmit byte buffer and its ready/valid handshake toward the UART TX.
  - Pop strobe toward the UART RX on data reads.
  - The four performance counters and their software reset.
- Its counter and status outputs feed the IO read mux.

Parameters:
- UART_RX_ADDR, 32'h80000004, UART receive-data address (load pops RX).
- UART_TX_ADDR, 32'h80000008, UART transmit-data address (store pushes TX).
- CNT_RST_ADDR, 32'h80000018, store of any data clears all counters.
- CW, 32, counter width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- addr  input  32  stage-3 data address (ALU result)
- wdata  input  32  stage-3 store data
- io_we  input  1  stage-3 store targeting IO region, already stall/flush qualified
- io_re  input  1  stage-3 load targeting IO region, already stall/flush qualified
- instr_retire  input  1  one instruction retires this cycle
- br_retire  input  1  retiring instruction is a conditional branch
- br_correct  input  1  that branch was predicted correctly (ignored unless br_retire)
- uart_tx_ready  input  1  UART TX can accept a byte
- uart_tx_data_in  output  8  byte to transmit
- uart_tx_data_in_valid  output  1  byte valid toward UART TX
- uart_rx_data_out_ready  output  1  pop strobe toward UART RX
- tx_ready_status  output  1  software-visible TX-ready bit for the read mux
- tx_overrun  output  1  sticky, store to TX while a byte was pending
- cyc_counter  output  CW  cycles since reset/clear
- instr_counter  output  CW  retired instructions
- br_instr_counter  output  CW  retired branches
- correct_br_counter  output  CW  correctly predicted branches

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are 0 immediately:
  - all four counters
  - uart_tx_data_in, uart_tx_data_in_valid
  - the pending flag
  - tx_overrun
- Any pending byte is discarded, including on reset mid-handshake.
- Address decode is exact 32-bit compare. Stores to other IO addresses are ignored.

TX buffer (one entry, states IDLE/PENDING):
- IDLE, io_we && addr==UART_TX_ADDR at cycle N:
  - uart_tx_data_in <= wdata[7:0].
  - PENDING; valid high from N+1.
- PENDING: valid stays high and data stays stable until a cycle with valid && uart_tx_ready. Next cycle goes to IDLE, valid low.
- PENDING, a new TX store in the same cycle as the handshake: accepted. New byte loaded, remains PENDING, no overrun.
- PENDING, TX store without handshake: store dropped, tx_overrun <= 1. Cleared only by reset.
- tx_ready_status = uart_tx_ready && !PENDING (combinational), so polling software never overruns.

RX pop:
- uart_rx_data_out_ready = io_re && addr==UART_RX_ADDR (combinational, same cycle as the read mux samples RX data).
- Exactly one pulse per qualified load. Reads of other addresses never pop.

Counters (CW-bit, wrap modulo 2^CW, no saturation):
- cyc_counter +1 every cycle.
- instr_counter +1 when instr_retire.
- br_instr_counter +1 when br_retire.
- correct_br_counter +1 when br_retire && br_correct.
- io_we && addr==CNT_RST_ADDR at cycle N: all four counters read 0 at N+1. The clear beats any increment in cycle N; increments resume at N+1 (cyc_counter=1 at N+2).
- Counter updates are independent of TX state.

Decomposition:
- Shared package/header: the IO address constants (UART_CTRL 0x80000000, RX 0x80000004, TX 0x80000008, cycle 0x80000010, instr 0x80000014, reset 0x80000018, branch 0x8000001c, correct-branch 0x80000020) and the IO-region prefix 2'b10. The read-side control uses the same constants.
- One natural sub-module, perf_counter: CW-bit register with inc and sync clear (clear priority), instantiated four times.
- TX buffer and RX strobe stay inline.

Test Plan:
- Reset release, idle 10 cycles -> cyc_counter=10, other counters 0, valid=0, tx_ready_status follows uart_tx_ready.
- uart_tx_ready=1, store 0x00000041 to 0x80000008 at N -> valid=1, data=0x41 at N+1, handshake, valid=0 at N+2.
- uart_tx_ready=0, store 0x41 then 0x42 -> data stays 0x41, tx_overrun=1, tx_ready_status=0. Raise ready -> 0x41 sent, then valid=0.
- br_retire=1 five cycles with br_correct=1,0,1,1,0 and instr_retire=1 -> br_instr_counter=5, correct_br_counter=3, instr_counter=5. Store to 0x80000018 during the last increment -> all 0 next cycle.
- Load from 0x80000004 -> single-cycle uart_rx_data_out_ready. Load from 0x80000000 -> no pulse.
- Force cyc_counter to 0xFFFFFFFF -> 0 next cycle. rst_n low while valid=1 -> valid drops without waiting for a clock.

Source files
------------

// File: rtl/mmio_write_unit_pkg.sv
// Shared constants for the memory-mapped IO region.
// Both the store-side unit and the read mux decode against these addresses.
package mmio_write_unit_pkg;

    // Top two address bits that select the IO region
    localparam logic [1:0]  IO_PREFIX        = 2'b10;

    // Register map of the IO region
    localparam logic [31:0] UART_CTRL_ADDR   = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR     = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;
    localparam logic [31:0] CYC_CNT_ADDR     = 32'h8000_0010;
    localparam logic [31:0] INSTR_CNT_ADDR   = 32'h8000_0014;
    localparam logic [31:0] CNT_RST_ADDR     = 32'h8000_0018;
    localparam logic [31:0] BR_CNT_ADDR      = 32'h8000_001c;
    localparam logic [31:0] CORR_BR_CNT_ADDR = 32'h8000_0020;

    // Default width of the performance counters
    localparam int          CW_DEFAULT       = 32;

    // Register selects use a full 32-bit compare so aliases never hit
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] target);
        return (addr == target);
    endfunction

endpackage

// File: rtl/mmio_write_unit_if.sv
// Bundle of stage-3 IO bus, retirement, UART and counter signals.
// The slave modport is the write unit; the master modport is its environment.
interface mmio_write_unit_if #(
    parameter int CW = 32
);
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          io_we;
    logic          io_re;
    logic          instr_retire;
    logic          br_retire;
    logic          br_correct;
    logic          uart_tx_ready;
    logic [7:0]    uart_tx_data_in;
    logic          uart_tx_data_in_valid;
    logic          uart_rx_data_out_ready;
    logic          tx_ready_status;
    logic          tx_overrun;
    logic [CW-1:0] cyc_counter;
    logic [CW-1:0] instr_counter;
    logic [CW-1:0] br_instr_counter;
    logic [CW-1:0] correct_br_counter;

    modport slave (
        input  addr, wdata, io_we, io_re,
        input  instr_retire, br_retire, br_correct,
        input  uart_tx_ready,
        output uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
        output tx_ready_status, tx_overrun,
        output cyc_counter, instr_counter, br_instr_counter, correct_br_counter
    );

    modport master (
        output addr, wdata, io_we, io_re,
        output instr_retire, br_retire, br_correct,
        output uart_tx_ready,
        input  uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
        input  tx_ready_status, tx_overrun,
        input  cyc_counter, instr_counter, br_instr_counter, correct_br_counter
    );

endinterface

// File: rtl/mmio_write_unit_perf_counter.sv
// Single performance counter: wraps modulo 2^CW, synchronous clear wins over increment.
module perf_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    // Clear has priority so a software reset is never lost to a same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mmio_write_unit.sv
// Store-side half of the IO region: UART TX buffer, RX pop strobe and
// the four performance counters with their software clear.
module mmio_write_unit
    import mmio_write_unit_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_write_unit_if.slave   bus
);

    localparam logic [0:0] TX_IDLE    = 1'b0;
    localparam logic [0:0] TX_PENDING = 1'b1;

    logic [0:0] tx_state;
    logic [7:0] tx_data;
    logic       tx_overrun_q;
    logic       tx_store;
    logic       tx_handshake;
    logic       tx_accept;
    logic       cnt_clear;
    logic       correct_inc;
    logic       one_cycle;

    // Decode of the qualified stage-3 access and the TX handshake
    always_comb begin
        tx_store     = bus.io_we && addr_hit(bus.addr, UART_TX_ADDR);
        cnt_clear    = bus.io_we && addr_hit(bus.addr, CNT_RST_ADDR);
        tx_handshake = (tx_state == TX_PENDING) && bus.uart_tx_ready;
        tx_accept    = tx_store && ((tx_state == TX_IDLE) || tx_handshake);
        correct_inc  = bus.br_retire && bus.br_correct;
        one_cycle    = 1'b1;
    end

    // One-entry TX buffer; a store during the draining cycle refills it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_data  <= 8'h00;
        end else if (tx_accept) begin
            tx_state <= TX_PENDING;
            tx_data  <= bus.wdata[7:0];
        end else if (tx_handshake) begin
            tx_state <= TX_IDLE;
        end
    end

    // Sticky flag for a TX store that found the buffer still full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_overrun_q <= 1'b0;
        end else if (tx_store && !tx_accept) begin
            tx_overrun_q <= 1'b1;
        end
    end

    // Outputs toward the UART and the read mux
    always_comb begin
        bus.uart_tx_data_in        = tx_data;
        bus.uart_tx_data_in_valid  = (tx_state == TX_PENDING);
        bus.tx_ready_status        = bus.uart_tx_ready && (tx_state == TX_IDLE);
        bus.tx_overrun             = tx_overrun_q;
        bus.uart_rx_data_out_ready = bus.io_re && addr_hit(bus.addr, UART_RX_ADDR);
    end

    perf_counter #(.CW(CW)) u_cyc_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (one_cycle),
        .clr   (cnt_clear),
        .count (bus.cyc_counter)
    );

    perf_counter #(.CW(CW)) u_instr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.instr_retire),
        .clr   (cnt_clear),
        .count (bus.instr_counter)
    );

    perf_counter #(.CW(CW)) u_br_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.br_retire),
        .clr   (cnt_clear),
        .count (bus.br_instr_counter)
    );

    perf_counter #(.CW(CW)) u_correct_br_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (correct_inc),
        .clr   (cnt_clear),
        .count (bus.correct_br_counter)
    );

endmodule

// File: tb/tb_mmio_write_unit.sv
// Directed bench for mmio_write_unit: TX buffer, RX strobe, counters, reset.
// A second 4-bit-counter instance exercises counter wrap in a few cycles.
module tb_mmio_write_unit;
    import mmio_write_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic rst_small_n;
    int   vectors;
    int   miscompares;

    mmio_write_unit_if #(.CW(32)) bus ();
    mmio_write_unit_if #(.CW(4))  bus_s ();

    mmio_write_unit #(.CW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mmio_write_unit #(.CW(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_small_n),
        .bus   (bus_s.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                                 input logic [31:0] d, input logic ir, input logic br,
                                 input logic bc);
        bus.io_we        = we;
        bus.io_re        = re;
        bus.addr         = a;
        bus.wdata        = d;
        bus.instr_retire = ir;
        bus.br_retire    = br;
        bus.br_correct   = bc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        rst_small_n = 1'b0;
        bus.uart_tx_ready    = 1'b0;
        bus_s.io_we          = 1'b0;
        bus_s.io_re          = 1'b0;
        bus_s.addr           = 32'h0;
        bus_s.wdata          = 32'h0;
        bus_s.instr_retire   = 1'b0;
        bus_s.br_retire      = 1'b0;
        bus_s.br_correct     = 1'b0;
        bus_s.uart_tx_ready  = 1'b0;
        idle();
        repeat (2) step();

        // Reset state
        checkOutput("rst_cyc",     bus.cyc_counter, 32'd0);
        checkOutput("rst_valid",   {31'd0, bus.uart_tx_data_in_valid}, 32'd0);
        checkOutput("rst_data",    {24'd0, bus.uart_tx_data_in}, 32'd0);
        checkOutput("rst_overrun", {31'd0, bus.tx_overrun}, 32'd0);

        // Release and idle ten cycles
        rst_n       = 1'b1;
        rst_small_n = 1'b1;
        repeat (10) step();
        checkOutput("idle_cyc",   bus.cyc_counter, 32'd10);
        checkOutput("idle_instr", bus.instr_counter, 32'd0);
        checkOutput("idle_br",    bus.br_instr_counter, 32'd0);
        checkOutput("idle_cbr",   bus.correct_br_counter, 32'd0);
        checkOutput("idle_valid", {31'd0, bus.uart_tx_data_in_valid}, 32'd0);
        bus.uart_tx_ready = 1'b1;
        #1;
        checkOutput("idle_status_hi", {31'd0, bus.tx_ready_status}, 32'd1);
        bus.uart_tx_ready = 1'b0;
        #1;
        checkOutput("idle_status_lo", {31'd0, bus.tx_ready_status}, 32'd0);

        // TX store with receiver ready: one-cycle pending then drained
        bus.uart_tx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0041, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("tx1_valid",  {31'd0, bus.uart_tx_data_in_valid}, 32'd1);
        checkOutput("tx1_data",   {24'd0, bus.uart_tx_data_in}, 32'h41);
        checkOutput("tx1_status", {31'd0, bus.tx_ready_status}, 32'd0);
        step();
        checkOutput("tx1_drain",  {31'd0, bus.uart_tx_data_in_valid}, 32'd0);
        checkOutput("tx1_status_back", {31'd0, bus.tx_ready_status}, 32'd1);

        // Store to a non-TX IO address is ignored
        applyStimulus(1'b1, 1'b0, 32'h8000_000c, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("other_addr_valid", {31'd0, bus.uart_tx_data_in_valid}, 32'd0);

        // Store in the handshake cycle refills the buffer without overrun
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0061, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0062, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("refill_valid",   {31'd0, bus.uart_tx_data_in_valid}, 32'd1);
        checkOutput("refill_data",    {24'd0, bus.uart_tx_data_in}, 32'h62);
        checkOutput("refill_overrun", {31'd0, bus.tx_overrun}, 32'd0);
        step();
        checkOutput("refill_drain",   {31'd0, bus.uart_tx_data_in_valid}, 32'd0);

        // Receiver stalled: second store dropped, overrun latched
        bus.uart_tx_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0041, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("ovr_valid1", {31'd0, bus.uart_tx_data_in_valid}, 32'd1);
        checkOutput("ovr_data1",  {24'd0, bus.uart_tx_data_in}, 32'h41);
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0042, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("ovr_data2",   {24'd0, bus.uart_tx_data_in}, 32'h41);
        checkOutput("ovr_valid2",  {31'd0, bus.uart_tx_data_in_valid}, 32'd1);
        checkOutput("ovr_flag",    {31'd0, bus.tx_overrun}, 32'd1);
        checkOutput("ovr_status",  {31'd0, bus.tx_ready_status}, 32'd0);
        bus.uart_tx_ready = 1'b1;
        #1;
        checkOutput("ovr_status_pending", {31'd0, bus.tx_ready_status}, 32'd0);
        step();
        checkOutput("ovr_drain",   {31'd0, bus.uart_tx_data_in_valid}, 32'd0);
        checkOutput("ovr_status_idle", {31'd0, bus.tx_ready_status}, 32'd1);
        checkOutput("ovr_sticky",  {31'd0, bus.tx_overrun}, 32'd1);

        // Retirement counters: five branches, pattern 1,0,1,1,0
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        checkOutput("cnt_instr", bus.instr_counter, 32'd5);
        checkOutput("cnt_br",    bus.br_instr_counter, 32'd5);
        checkOutput("cnt_cbr",   bus.correct_br_counter, 32'd3);

        // br_correct without br_retire is ignored
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        checkOutput("cnt_cbr_ignored", bus.correct_br_counter, 32'd3);

        // Software clear beats a same-cycle increment
        applyStimulus(1'b1, 1'b0, CNT_RST_ADDR, 32'h0000_dead, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("clr_cyc",   bus.cyc_counter, 32'd0);
        checkOutput("clr_instr", bus.instr_counter, 32'd0);
        checkOutput("clr_br",    bus.br_instr_counter, 32'd0);
        checkOutput("clr_cbr",   bus.correct_br_counter, 32'd0);
        step();
        checkOutput("clr_resume_cyc",   bus.cyc_counter, 32'd1);
        checkOutput("clr_resume_instr", bus.instr_counter, 32'd0);

        // RX pop strobe only for loads of the RX data register
        applyStimulus(1'b0, 1'b1, UART_RX_ADDR, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rx_pop",     {31'd0, bus.uart_rx_data_out_ready}, 32'd1);
        step();
        idle();
        checkOutput("rx_pop_end", {31'd0, bus.uart_rx_data_out_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, UART_CTRL_ADDR, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rx_ctrl_nopop", {31'd0, bus.uart_rx_data_out_ready}, 32'd0);
        applyStimulus(1'b1, 1'b0, UART_RX_ADDR, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rx_store_nopop", {31'd0, bus.uart_rx_data_out_ready}, 32'd0);
        idle();

        // Counter wrap on the narrow instance
        rst_small_n = 1'b0;
        #1;
        checkOutput("wrap_rst", {28'd0, bus_s.cyc_counter}, 32'd0);
        rst_small_n = 1'b1;
        repeat (15) step();
        checkOutput("wrap_max",  {28'd0, bus_s.cyc_counter}, 32'd15);
        step();
        checkOutput("wrap_zero", {28'd0, bus_s.cyc_counter}, 32'd0);
        step();
        checkOutput("wrap_one",  {28'd0, bus_s.cyc_counter}, 32'd1);

        // Asynchronous reset while a byte is pending
        bus.uart_tx_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, UART_TX_ADDR, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("arst_pre_valid", {31'd0, bus.uart_tx_data_in_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid",   {31'd0, bus.uart_tx_data_in_valid}, 32'd0);
        checkOutput("arst_data",    {24'd0, bus.uart_tx_data_in}, 32'd0);
        checkOutput("arst_overrun", {31'd0, bus.tx_overrun}, 32'd0);
        checkOutput("arst_cyc",     bus.cyc_counter, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("arst_after_valid", {31'd0, bus.uart_tx_data_in_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
